// File: rtl/battleship_pkg.sv
// Shared types and defaults for the battleship master link: FSM state
// encoding, winner codes, timing defaults and a one-hot helper.
package battleship_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_OK,
    LOAD,
    TURN_A,
    SEND_A,
    CHECK_A,
    TURN_B,
    CHECK_B,
    WIN_A,
    WIN_B
  } state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_A    = 2'b01;
  localparam logic [1:0] WINNER_B    = 2'b10;

  localparam int PULSE_CYC_DEF  = 2;
  localparam int SETTLE_CYC_DEF = 8;
  localparam int STABLE_CYC_DEF = 4;

  // True when exactly one bit of a board-sized vector is set.
  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
  endfunction

endpackage

// File: rtl/master_link_if.sv
// Wires between the master board and the remote slave board.
//
// Handshake: there is no ready signal. The master places data on A (or B)
// and raises LDR1B (or LDR2B) for a fixed number of clocks; the data is
// valid and stable for every cycle the strobe is high. The slave answers
// asynchronously through OKB, LivB and B_Attack, which the master
// synchronizes before use. B_Attack is a shot only once it has returned to
// zero and then held one one-hot value for the stability window.
interface master_link_if;
  logic [15:0] A;
  logic [15:0] B;
  logic        LDR1B;
  logic        LDR2B;
  logic        ST;
  logic        DispB;
  logic        LivB;
  logic        OKB;
  logic [15:0] B_Attack;

  modport master (
    output A, B, LDR1B, LDR2B, ST, DispB,
    input  LivB, OKB, B_Attack
  );

  modport slave (
    input  A, B, LDR1B, LDR2B, ST, DispB,
    output LivB, OKB, B_Attack
  );
endinterface

// File: rtl/bs_sync_filter.sv
// Two-flop synchronizer followed by an equality filter: q is the latest
// synchronized sample and stable is high once q has been seen unchanged for
// STABLE_CYC consecutive cycles.
module bs_sync_filter #(
  parameter int WIDTH      = 16,
  parameter int STABLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             stable
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYC);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CW-1:0]    run;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  // Count how many consecutive synchronized samples matched, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      run <= '0;
    end else begin
      q <= s2;
      if (s2 != q) begin
        run <= CW'(1);
      end else if (run != RUN_MAX) begin
        run <= run + CW'(1);
      end
    end
  end

  assign stable = (run == RUN_MAX);

endmodule

// File: rtl/master_link.sv
// Battleship master: runs the game between local player A and a remote
// slave board B, strobing A's map and shots out and filtering B's replies.
module master_link
  import battleship_pkg::*;
#(
  parameter int PULSE_CYC  = PULSE_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic           a_ok,
  input  logic [15:0]    a_map,
  input  logic           a_fire,
  input  logic [15:0]    a_attack,
  master_link_if.master  link,
  output logic           hit_a,
  output logic [1:0]     winner,
  output state_t         state_dbg
);

  localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  logic [1:0]  rst_sync;
  logic        rst_n;
  state_t      state;
  logic [15:0] amap_reg;
  logic [15:0] b_reg;
  logic [15:0] shot;
  logic [7:0]  cnt;
  logic        armed;
  logic        ldr1b;
  logic        ldr2b;
  logic        st;
  logic        dispb;
  logic        okb_q;
  logic        okb_stable;
  logic        livb_q;
  logic        livb_stable;
  logic [15:0] batk_q;
  logic        batk_stable;

  // Reset asserts immediately with clr and releases two clocks after it.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  bs_sync_filter #(.WIDTH(1), .STABLE_CYC(1)) u_okb (
    .clk(clk), .rst_n(rst_n), .d(link.OKB), .q(okb_q), .stable(okb_stable)
  );

  bs_sync_filter #(.WIDTH(1), .STABLE_CYC(1)) u_livb (
    .clk(clk), .rst_n(rst_n), .d(link.LivB), .q(livb_q), .stable(livb_stable)
  );

  bs_sync_filter #(.WIDTH(16), .STABLE_CYC(STABLE_CYC)) u_batk (
    .clk(clk), .rst_n(rst_n), .d(link.B_Attack), .q(batk_q), .stable(batk_stable)
  );

  // Game sequencer; every output it drives is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      amap_reg <= '0;
      b_reg    <= '0;
      shot     <= '0;
      cnt      <= '0;
      armed    <= 1'b0;
      ldr1b    <= 1'b0;
      ldr2b    <= 1'b0;
      st       <= 1'b0;
      dispb    <= 1'b0;
      hit_a    <= 1'b0;
      winner   <= WINNER_NONE;
    end else begin
      hit_a <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= WAIT_OK;
        end
        WAIT_OK: begin
          if (a_ok && okb_q && okb_stable) begin
            amap_reg <= a_map;
            ldr1b    <= 1'b1;
            st       <= 1'b1;
            cnt      <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (cnt == PULSE_LAST) begin
            ldr1b <= 1'b0;
            state <= TURN_A;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        TURN_A: begin
          if (a_fire && is_onehot(a_attack)) begin
            b_reg <= a_attack;
            ldr2b <= 1'b1;
            cnt   <= '0;
            state <= SEND_A;
          end
        end
        SEND_A: begin
          if (cnt == PULSE_LAST) begin
            ldr2b <= 1'b0;
            cnt   <= '0;
            state <= CHECK_A;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        CHECK_A: begin
          if (cnt == SETTLE_LAST) begin
            if (livb_q && livb_stable) begin
              dispb <= 1'b1;
              armed <= 1'b0;
              state <= TURN_B;
            end else begin
              winner <= WINNER_A;
              st     <= 1'b0;
              state  <= WIN_A;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        TURN_B: begin
          // A stale shot left on the bus must clear to zero before arming.
          if (!armed) begin
            if (batk_q == 16'h0000) armed <= 1'b1;
          end else if (batk_stable && is_onehot(batk_q)) begin
            shot  <= batk_q;
            dispb <= 1'b0;
            state <= CHECK_B;
          end
        end
        CHECK_B: begin
          hit_a    <= |(shot & amap_reg);
          amap_reg <= amap_reg & ~shot;
          if ((amap_reg & ~shot) == 16'h0000) begin
            winner <= WINNER_B;
            st     <= 1'b0;
            state  <= WIN_B;
          end else begin
            state <= TURN_A;
          end
        end
        WIN_A, WIN_B: begin
          if (start) begin
            winner   <= WINNER_NONE;
            amap_reg <= '0;
            b_reg    <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign link.A     = amap_reg;
  assign link.B     = b_reg;
  assign link.LDR1B = ldr1b;
  assign link.LDR2B = ldr2b;
  assign link.ST    = st;
  assign link.DispB = dispb;
  assign state_dbg  = state;

endmodule

// File: tb/tb_master_link.sv
// Directed-plus-random bench for master_link with a board-level game model.
module tb_master_link;
  import battleship_pkg::*;

  localparam int PULSE  = 2;
  localparam int SETTLE = 8;
  localparam int STABLE = 4;

  logic        clk;
  logic        clr;
  logic        start;
  logic        a_ok;
  logic [15:0] a_map;
  logic        a_fire;
  logic [15:0] a_attack;
  logic        hit_a;
  logic [1:0]  winner;
  state_t      state_dbg;

  master_link_if link();

  master_link #(.PULSE_CYC(PULSE), .SETTLE_CYC(SETTLE), .STABLE_CYC(STABLE)) dut (
    .clk(clk), .clr(clr), .start(start), .a_ok(a_ok), .a_map(a_map),
    .a_fire(a_fire), .a_attack(a_attack), .link(link.master),
    .hit_a(hit_a), .winner(winner), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not complete within cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int hit_total = 0;
  int model_hits = 0;
  logic [15:0] model_map;
  logic [15:0] exp_q[$];

  always @(posedge clk) if (hit_a === 1'b1) hit_total++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic fire(input logic [15:0] shot);
    a_attack = shot;
    a_fire   = 1'b1;
    step(1);
    a_fire   = 1'b0;
    a_attack = '0;
  endtask

  task automatic wait_for_state(input string tag, input state_t tgt, input int budget);
    int n = 0;
    while (state_dbg !== tgt && n < budget) begin
      step(1);
      n++;
    end
    check(tag, state_dbg, tgt);
  endtask

  task automatic new_game(input string tag, input logic [15:0] map);
    a_map = map;
    a_ok = 1'b1;
    link.OKB = 1'b1;
    pulse_start();
    wait_for_state({tag, "_turn_a"}, TURN_A, 40);
    check({tag, "_A"}, link.A, map);
    check({tag, "_ST"}, link.ST, 1'b1);
    model_map = map;
  endtask

  // A fires; optional decoy fire during the strobe must be ignored.
  task automatic a_turn(input string tag, input logic [15:0] shot, input logic livb,
                        input logic [15:0] decoy);
    int hi = 0;
    link.LivB = livb;
    check({tag, "_in_turn_a"}, state_dbg, TURN_A);
    fire(shot);
    if (decoy != 16'h0) begin
      a_fire = 1'b1;
      a_attack = decoy;
    end
    while (link.LDR2B === 1'b1 && hi < 10) begin
      step(1);
      a_fire = 1'b0;
      a_attack = '0;
      hi++;
    end
    a_fire = 1'b0;
    check({tag, "_ldr2b_len"}, hi, PULSE);
    check({tag, "_B"}, link.B, shot);
    if (livb) begin
      wait_for_state({tag, "_to_turn_b"}, TURN_B, 40);
      check({tag, "_dispb"}, link.DispB, 1'b1);
    end else begin
      wait_for_state({tag, "_to_win_a"}, WIN_A, 40);
      check({tag, "_winner"}, winner, WINNER_A);
      check({tag, "_ST0"}, link.ST, 1'b0);
      check({tag, "_dispb0"}, link.DispB, 1'b0);
    end
  endtask

  // B shoots; model decides hit/miss and new board, scoreboard compares.
  task automatic b_turn(input string tag, input logic [15:0] shot);
    int hits = 0;
    int n = 0;
    logic exp_hit;
    logic [15:0] exp_a;
    exp_hit = (shot & model_map) != 16'h0;
    model_map = model_map & ~shot;
    exp_q.push_back(model_map);
    if (exp_hit) model_hits++;
    link.B_Attack = shot;
    while (n < 40 && !(state_dbg == TURN_A || state_dbg == WIN_B)) begin
      step(1);
      if (hit_a === 1'b1) hits++;
      n++;
    end
    link.B_Attack = '0;
    check({tag, "_hit"}, hits, {31'd0, exp_hit});
    exp_a = exp_q.pop_front();
    check({tag, "_A"}, link.A, exp_a);
    check({tag, "_dispb0"}, link.DispB, 1'b0);
    if (model_map == 16'h0) begin
      check({tag, "_state"}, state_dbg, WIN_B);
      check({tag, "_winner"}, winner, WINNER_B);
      check({tag, "_ST0"}, link.ST, 1'b0);
    end else begin
      check({tag, "_state"}, state_dbg, TURN_A);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi;
    int n;
    logic [15:0] shot;
    logic livb;
    int k;

    clr = 1'b0; start = 1'b0; a_ok = 1'b0; a_map = '0; a_fire = 1'b0; a_attack = '0;
    link.LivB = 1'b1; link.OKB = 1'b0; link.B_Attack = '0;
    step(3);
    check("rst_state", state_dbg, IDLE);
    check("rst_A", link.A, 16'h0);
    check("rst_B", link.B, 16'h0);
    check("rst_ldr", {link.LDR1B, link.LDR2B, link.ST, link.DispB, hit_a}, 5'b0);
    check("rst_winner", winner, WINNER_NONE);
    clr = 1'b1;
    step(4);
    check("post_rst_idle", state_dbg, IDLE);

    // Placement: hold in WAIT_OK until the slave confirms.
    a_map = 16'h000F; a_ok = 1'b1; link.OKB = 1'b0;
    pulse_start();
    wait_for_state("wait_ok", WAIT_OK, 4);
    step(6);
    check("hold_wait_ok", state_dbg, WAIT_OK);
    link.OKB = 1'b1;
    n = 0;
    while (link.LDR1B !== 1'b1 && n < 12) begin step(1); n++; end
    hi = 0;
    while (link.LDR1B === 1'b1 && hi < 10) begin
      check("A_during_ldr1b", link.A, 16'h000F);
      step(1);
      hi++;
    end
    check("ldr1b_len", hi, PULSE);
    check("load_turn_a", state_dbg, TURN_A);
    check("load_ST", link.ST, 1'b1);
    a_map = 16'hFFFF;
    step(1);
    check("A_latched", link.A, 16'h000F);
    model_map = 16'h000F;
    pulse_start();
    step(2);
    check("start_ignored", state_dbg, TURN_A);

    // Non-one-hot shot is ignored, then a valid one goes out.
    fire(16'h0030);
    step(3);
    check("bad_fire_state", state_dbg, TURN_A);
    check("bad_fire_ldr2b", link.LDR2B, 1'b0);
    check("bad_fire_B", link.B, 16'h0);
    a_turn("t1", 16'h0010, 1'b1, 16'h0800);

    // Three-cycle hold is too short to count as a shot.
    link.B_Attack = 16'h0001;
    step(3);
    link.B_Attack = 16'h0000;
    step(10);
    check("short_hold_state", state_dbg, TURN_B);
    check("short_hold_nohit", hit_total, 0);
    b_turn("b1", 16'h0001);
    check("b1_A_000E", link.A, 16'h000E);

    a_turn("t2", 16'h0100, 1'b1, 16'h0);
    b_turn("b_repeat", 16'h0001);
    a_turn("t3", 16'h0200, 1'b1, 16'h0);
    b_turn("b2", 16'h0002);
    a_turn("t4", 16'h0400, 1'b1, 16'h0);
    b_turn("b3", 16'h0004);
    a_turn("t5", 16'h0800, 1'b1, 16'h0);
    b_turn("b4", 16'h0008);
    pulse_start();
    step(2);
    check("win_b_to_idle", state_dbg, IDLE);
    check("idle_winner", winner, WINNER_NONE);

    // B has no ships left when sampled: A wins.
    new_game("g43", 16'h00F0);
    a_turn("t43", 16'h0004, 1'b0, 16'h0);
    pulse_start();
    step(2);
    check("win_a_to_idle", state_dbg, IDLE);

    // Randomized games against the board model.
    for (int g = 0; g < 3; g++) begin
      new_game("rg", (16'($urandom) & 16'h0F0F) | (16'h0001 << $urandom_range(0, 15)));
      for (int r = 0; r < 40; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          fire(16'h0003 << $urandom_range(0, 14));
          step(2);
          check("rg_bad_fire", state_dbg, TURN_A);
        end
        livb = (g == 0) ? ($urandom_range(0, 9) != 0) : 1'b1;
        a_turn("rg_a", 16'h0001 << $urandom_range(0, 15), livb,
               (r % 2 == 0) ? 16'h8000 : 16'h0);
        if (!livb) break;
        shot = 16'h0001 << $urandom_range(0, 15);
        if ($urandom_range(0, 3) != 0) begin
          for (int t = 0; t < 64; t++) begin
            k = $urandom_range(0, 15);
            if (model_map[k]) begin
              shot = 16'h0001 << k;
              break;
            end
          end
        end
        b_turn("rg_b", shot);
        if (model_map == 16'h0) break;
      end
      if (state_dbg == WIN_A || state_dbg == WIN_B) begin
        pulse_start();
      end else begin
        clr = 1'b0;
        step(1);
        clr = 1'b1;
      end
      step(4);
      check("rg_idle", state_dbg, IDLE);
    end

    // Reset in the middle of the shot strobe clears outputs at once.
    new_game("g44", 16'h0033);
    link.LivB = 1'b1;
    fire(16'h0002);
    check("g44_ldr2b_high", link.LDR2B, 1'b1);
    clr = 1'b0;
    #1;
    check("g44_ldr2b_drop", link.LDR2B, 1'b0);
    check("g44_outs", {link.LDR1B, link.ST, link.DispB, hit_a}, 4'b0);
    check("g44_AB", {link.A, link.B}, 32'h0);
    check("g44_state", state_dbg, IDLE);
    step(2);
    clr = 1'b1;
    step(4);
    check("g44_idle_after", state_dbg, IDLE);
    check("g44_winner", winner, WINNER_NONE);

    check("hit_pulse_total", hit_total, model_hits);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/master_link.md
MASTER_LINK -- requirements
Module: master_link

Interface
REQ-001 Parameter PULSE_CYC, default 2: LDR1B/LDR2B high time, in clk cycles.
REQ-002 Parameter SETTLE_CYC, default 8: wait after LDR2B falls before sampling LivB.
REQ-003 Parameter STABLE_CYC, default 4: consecutive equal synchronized B_Attack samples needed to accept a shot.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 clr  in  1  reset; asynchronous assert, active-low, synchronous deassert.
REQ-006 start  in  1  debounced one-cycle pulse; begins or restarts a game.
REQ-007 a_ok  in  1  level; local player A confirms ship placement.
REQ-008 a_map  in  16  local player A ship map, one bit per square.
REQ-009 a_fire  in  1  one-cycle pulse; A commits a shot.
REQ-010 a_attack  in  16  A's shot; valid only when one-hot.
REQ-011 LivB  in  1  slave: B has ships remaining; asynchronous to clk.
REQ-012 OKB  in  1  slave: B placement done; asynchronous.
REQ-013 B_Attack  in  16  slave: B's shot, one-hot; asynchronous.
REQ-014 A  out  16  A's current ship map, driven to slave.
REQ-015 B  out  16  A's shot, driven to slave.
REQ-016 LDR1B  out  1  slave load strobe for A.
REQ-017 LDR2B  out  1  slave load strobe for B.
REQ-018 ST  out  1  game running; high from LOAD through the end of play.
REQ-019 DispB  out  1  high only in TURN_B.
REQ-020 hit_a  out  1  one-cycle pulse when B's shot hits A.
REQ-021 winner  out  2  00 none, 01 A, 10 B.

Function
REQ-022 LivB, OKB and B_Attack SHALL each pass through a 2-flop synchronizer before any use.
REQ-023 States: IDLE, WAIT_OK, LOAD, TURN_A, SEND_A, CHECK_A, TURN_B, CHECK_B, WIN_A, WIN_B.
REQ-024 IDLE -> WAIT_OK on start; WAIT_OK -> LOAD when a_ok and synced OKB are both high; LOAD latches a_map into amap_reg and drives A=amap_reg.
REQ-025 LOAD SHALL hold LDR1B high for exactly PULSE_CYC cycles, A stable from the first strobe cycle, then enter TURN_A.
REQ-026 TURN_A: a_fire with one-hot a_attack SHALL latch B=a_attack and enter SEND_A; a_fire with a non-one-hot a_attack is ignored.
REQ-027 SEND_A SHALL hold LDR2B high for exactly PULSE_CYC cycles; CHECK_A then waits SETTLE_CYC cycles and samples synced LivB: 0 -> WIN_A, 1 -> TURN_B.
REQ-028 TURN_B SHALL arm only after synced B_Attack is seen as 16'h0000 at least once after entry.
REQ-029 Once armed, TURN_B SHALL accept a one-hot value held equal for STABLE_CYC consecutive cycles; non-one-hot values reset the stability count.
REQ-030 CHECK_B (one cycle) SHALL pulse hit_a iff (shot & amap_reg) != 0 and update amap_reg <= amap_reg & ~shot, with A following the update.
REQ-031 After CHECK_B, amap_reg == 0 SHALL lead to WIN_B; otherwise to TURN_A.
REQ-032 A repeat shot on an already-hit square SHALL be a miss with no state change.
REQ-033 WIN_A/WIN_B SHALL hold winner and drop ST; start returns to IDLE, and start in any other state is ignored.
REQ-034 In LOAD, SEND_A and CHECK_A, simultaneous a_fire or B_Attack activity SHALL be ignored.

Reset
REQ-035 On clr low, SHALL enter IDLE with A=0, B=0, LDR1B=0, LDR2B=0, ST=0, DispB=0, hit_a=0, winner=00, amap_reg=0, all counters and synchronizers 0.
REQ-036 Reset asserted mid-strobe SHALL drop LDR1B/LDR2B in the same instant (asynchronous).

Structure
REQ-037 battleship_pkg SHALL hold the state enum, winner encodings, and the PULSE_CYC/SETTLE_CYC/STABLE_CYC defaults.
REQ-038 Sub-module bs_sync_filter (2-flop synchronizer plus STABLE_CYC equality filter, WIDTH parameter) SHALL be used for B_Attack; the 1-bit signals use the same block with STABLE_CYC=1.

Verification
REQ-039 start; a_ok=1, OKB=1, a_map=16'h000F -> LDR1B high for 2 cycles, A=16'h000F, ST=1, state TURN_A.
REQ-040 a_fire with a_attack=16'h0030 -> ignored; a_fire with a_attack=16'h0010 -> B=16'h0010, LDR2B 2 cycles; with LivB=1 after settle -> DispB=1.
REQ-041 In TURN_B, B_Attack=16'h0001 held 3 cycles then changed -> no accept; held 4+ cycles after a prior 0 -> hit_a pulse, A=16'h000E.
REQ-042 B shoots 0x0002, 0x0004, 0x0008 (each preceded by 0) -> winner=10, ST=0; repeat 0x0001 earlier -> no hit_a.
REQ-043 LivB=0 at the CHECK_A sample -> winner=01; start -> IDLE.
REQ-044 clr low during LDR2B -> all outputs 0 immediately, IDLE after release.
